// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: packs symbolic MIPS operations into 32-bit instruction
// words for the instruction-memory loader. The block keeps its own write
// address and resolves beq/j targets from absolute byte addresses.
// The data path is a 2-stage valid/ready pipeline:
//   S1 captures the command with its address A and the word address of A+4.
//   S2 encodes the command and registers the result on the output ports.
module mips_instr_encoder #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter bit          ERR_NOP    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        addr_load,
    input  logic [31:0] addr_load_val,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [15:0] in_imm,
    input  logic [31:0] in_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic [1:0]  out_err,
    output logic        err_any
);

    // Symbolic operation codes on in_op
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LW   = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_J    = 4'd9;

    // Error codes on out_err
    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_ILL = 2'd1;
    localparam logic [1:0] ERR_BEQ = 2'd2;
    localparam logic [1:0] ERR_J   = 2'd3;

    localparam logic [31:0] START_ADDR = RESET_ADDR & ~32'h3;

    // Write address counter
    logic [31:0] r_addr;

    // Stage 1 registers
    logic        r_s1_valid;
    logic [3:0]  r_s1_op;
    logic [4:0]  r_s1_rs;
    logic [4:0]  r_s1_rt;
    logic [4:0]  r_s1_rd;
    logic [15:0] r_s1_imm;
    logic [31:0] r_s1_target;
    logic [31:0] r_s1_addr;
    logic [29:0] r_s1_p4w;     // word address of A+4; byte bits are always zero

    // Handshake and encoder wires
    logic        w_accept;
    logic        w_s2_load;
    logic        w_out_take;
    logic [30:0] w_disp;       // (target - P4) >>> 2, 31-bit signed
    logic        w_beq_ok;
    logic        w_j_ok;
    logic [31:0] w_instr;
    logic [1:0]  w_err;

    // S1 may move forward when S2 is empty or its word leaves this cycle
    assign w_out_take = out_valid & out_ready;
    assign w_s2_load  = r_s1_valid & (~out_valid | out_ready);
    assign in_ready   = ~addr_load & (~r_s1_valid | ~out_valid | out_ready);
    assign w_accept   = in_valid & in_ready;

    // P4 is word aligned, so the word-level difference equals the arithmetic
    // shift of the byte difference even when the target is misaligned.
    assign w_disp   = {1'b0, r_s1_target[31:2]} - {1'b0, r_s1_p4w};
    assign w_beq_ok = (r_s1_target[1:0] == 2'b00) &&
                      (w_disp[30:15] == {16{w_disp[30]}});
    assign w_j_ok   = (r_s1_target[1:0] == 2'b00) &&
                      (r_s1_target[31:28] == r_s1_p4w[29:26]);

    // Address counter: an explicit load wins over the increment on accept
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            r_addr <= START_ADDR;
        end else if (addr_load) begin
            r_addr <= addr_load_val & ~32'h3;
        end else if (w_accept) begin
            r_addr <= r_addr + 32'd4;
        end
    end

    // Stage 1: capture the command together with its address and P4
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= 4'd0;
            r_s1_rs     <= 5'd0;
            r_s1_rt     <= 5'd0;
            r_s1_rd     <= 5'd0;
            r_s1_imm    <= 16'd0;
            r_s1_target <= 32'd0;
            r_s1_addr   <= 32'd0;
            r_s1_p4w    <= 30'd0;
        end else if (w_accept) begin
            r_s1_valid  <= 1'b1;
            r_s1_op     <= in_op;
            r_s1_rs     <= in_rs;
            r_s1_rt     <= in_rt;
            r_s1_rd     <= in_rd;
            r_s1_imm    <= in_imm;
            r_s1_target <= in_target;
            r_s1_addr   <= r_addr;
            r_s1_p4w    <= r_addr[31:2] + 30'd1;
        end else if (w_s2_load) begin
            r_s1_valid  <= 1'b0;
        end
    end

    // Encoder: build the instruction word and error code from the S1 entry
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred for the unlisted opcodes.
        w_instr = 32'd0;
        w_err   = ERR_OK;
        case (r_s1_op)
            OP_ADD:  w_instr = {6'h00, r_s1_rs, r_s1_rt, r_s1_rd, 5'h00, 6'h20};
            OP_SUB:  w_instr = {6'h00, r_s1_rs, r_s1_rt, r_s1_rd, 5'h00, 6'h22};
            OP_AND:  w_instr = {6'h00, r_s1_rs, r_s1_rt, r_s1_rd, 5'h00, 6'h24};
            OP_OR:   w_instr = {6'h00, r_s1_rs, r_s1_rt, r_s1_rd, 5'h00, 6'h25};
            OP_SLT:  w_instr = {6'h00, r_s1_rs, r_s1_rt, r_s1_rd, 5'h00, 6'h2A};
            OP_ADDI: w_instr = {6'h08, r_s1_rs, r_s1_rt, r_s1_imm};
            OP_LW:   w_instr = {6'h23, r_s1_rs, r_s1_rt, r_s1_imm};
            OP_SW:   w_instr = {6'h2B, r_s1_rs, r_s1_rt, r_s1_imm};
            OP_BEQ: begin
                w_instr = {6'h04, r_s1_rs, r_s1_rt, w_disp[15:0]};
                if (!w_beq_ok) w_err = ERR_BEQ;
            end
            OP_J: begin
                w_instr = {6'h02, r_s1_target[27:2]};
                if (!w_j_ok) w_err = ERR_J;
            end
            default: begin
                w_instr = 32'd0;
                w_err   = ERR_ILL;
            end
        endcase
        if (ERR_NOP && (w_err != ERR_OK)) w_instr = 32'd0;
    end

    // Stage 2: output register, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_addr  <= 32'd0;
            out_err   <= ERR_OK;
        end else if (w_s2_load) begin
            out_valid <= 1'b1;
            out_instr <= w_instr;
            out_addr  <= r_s1_addr;
            out_err   <= w_err;
        end else if (w_out_take) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky error flag over delivered words; an address load clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_any <= 1'b0;
        end else if (addr_load) begin
            err_any <= 1'b0;
        end else if (w_out_take && (out_err != ERR_OK)) begin
            err_any <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Testbench for mips_instr_encoder: a scoreboard queue receives the expected
// word when a command is accepted and a monitor compares it when delivered.
module tb_mips_instr_encoder;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
    localparam logic [3:0] OP_SLT = 4'd4, OP_ADDI = 4'd5, OP_LW = 4'd6, OP_SW = 4'd7;
    localparam logic [3:0] OP_BEQ = 4'd8, OP_J = 4'd9;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic [1:0]  err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        addr_load;
    logic [31:0] addr_load_val;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [31:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic [1:0]  out_err;
    logic        err_any;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_addr;
    bit          rand_ready = 1'b0;

    always #5 clk = ~clk;

    mips_instr_encoder #(.RESET_ADDR(RESET_ADDR), .ERR_NOP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .addr_load(addr_load), .addr_load_val(addr_load_val),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
        .err_any(err_any)
    );

    // Reference encoder written from the instruction-format description
    function automatic exp_t model(input logic [3:0] op, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic [4:0] rd,
                                   input logic [15:0] imm, input logic [31:0] tgt,
                                   input logic [31:0] a);
        logic [31:0] p4;
        longint      d;
        longint      q;
        logic [63:0] dv;
        logic [31:0] w;
        logic [1:0]  e;
        p4 = a + 32'd4;
        w  = 32'd0;
        e  = 2'd0;
        case (op)
            OP_ADD:  w = {6'd0, rs, rt, rd, 5'd0, 6'h20};
            OP_SUB:  w = {6'd0, rs, rt, rd, 5'd0, 6'h22};
            OP_AND:  w = {6'd0, rs, rt, rd, 5'd0, 6'h24};
            OP_OR:   w = {6'd0, rs, rt, rd, 5'd0, 6'h25};
            OP_SLT:  w = {6'd0, rs, rt, rd, 5'd0, 6'h2A};
            OP_ADDI: w = {6'h08, rs, rt, imm};
            OP_LW:   w = {6'h23, rs, rt, imm};
            OP_SW:   w = {6'h2B, rs, rt, imm};
            OP_BEQ: begin
                d  = longint'({32'd0, tgt}) - longint'({32'd0, p4});
                dv = d;
                q  = d >>> 2;
                w  = {6'h04, rs, rt, dv[17:2]};
                if (tgt[1:0] != 2'b00 || q < -32768 || q > 32767) e = 2'd2;
            end
            OP_J: begin
                w = {6'h02, tgt[27:2]};
                if (tgt[1:0] != 2'b00 || tgt[31:28] != p4[31:28]) e = 2'd3;
            end
            default: e = 2'd1;
        endcase
        if (e != 2'd0) w = 32'd0;
        return '{instr: w, addr: a, err: e};
    endfunction

    // Scoreboard monitor: compare every delivered word with the queue head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got instr=%h addr=%h err=%0d, expected none",
                         out_instr, out_addr, out_err);
            end else begin
                e = sb.pop_front();
                if ({out_instr, out_addr, out_err} !== e) begin
                    errors++;
                    $display("FAIL word: got instr=%h addr=%h err=%0d, expected instr=%h addr=%h err=%0d",
                             out_instr, out_addr, out_err, e.instr, e.addr, e.err);
                end
            end
        end
    end

    // Random back-pressure on the output while enabled
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Offer one command and hold it until accepted; the expected word is
    // queued at acceptance (explicit value when use_exp, else the model).
    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [31:0] tgt,
                        input bit use_exp, input logic [31:0] e_instr, input logic [1:0] e_err);
        int waited = 0;
        in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_target = tgt;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, waited);
        end else begin
            if (use_exp) sb.push_back('{instr: e_instr, addr: m_addr, err: e_err});
            else         sb.push_back(model(op, rs, rt, rd, imm, tgt, m_addr));
            m_addr += 32'd4;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic load_addr(input logic [31:0] v);
        in_valid = 1'b0;
        addr_load = 1'b1;
        addr_load_val = v;
        @(posedge clk); #1;
        addr_load = 1'b0;
        m_addr = v & ~32'h3;
    endtask

    task automatic drain();
        int n = 0;
        idle();
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d words outstanding, expected 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; addr_load = 1'b0; addr_load_val = 32'd0; in_valid = 1'b0;
        in_op = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_imm = 16'd0;
        in_target = 32'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        m_addr = RESET_ADDR & ~32'h3;
        @(negedge clk);
        checks++;
        if ({out_valid, out_instr, out_addr, out_err, err_any, in_ready} !== {1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got v=%b instr=%h addr=%h err=%0d any=%b rdy=%b, expected 0/0/0/0/0/1",
                     out_valid, out_instr, out_addr, out_err, err_any, in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alu_mem();
        send(OP_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 32'd0, 1'b1, 32'h0022_1820, 2'd0);
        idle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: out_valid=%b one cycle after accept, expected 0", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h0022_1820) begin
            errors++;
            $display("FAIL latency_2: out_valid=%b instr=%h, expected 1 and 00221820", out_valid, out_instr);
        end
        drain();
        load_addr(32'h0);
        send(OP_LW, 5'd29, 5'd8, 5'd0, 16'h0004, 32'd0, 1'b1, 32'h8FA8_0004, 2'd0);
        send(OP_SW, 5'd29, 5'd8, 5'd0, 16'h0004, 32'd0, 1'b1, 32'hAFA8_0004, 2'd0);
        send(OP_SUB,  5'd4, 5'd5, 5'd6, 16'd0, 32'd0, 1'b1, 32'h0085_3022, 2'd0);
        send(OP_AND,  5'd7, 5'd8, 5'd9, 16'd0, 32'd0, 1'b1, 32'h00E8_4824, 2'd0);
        send(OP_OR,   5'd1, 5'd1, 5'd1, 16'd0, 32'd0, 1'b1, 32'h0021_0825, 2'd0);
        send(OP_SLT,  5'd31, 5'd30, 5'd29, 16'd0, 32'd0, 1'b1, 32'h03FE_E82A, 2'd0);
        send(OP_ADDI, 5'd2, 5'd3, 5'd0, 16'hFFFF, 32'd0, 1'b1, 32'h2043_FFFF, 2'd0);
        drain();
    endtask

    task automatic test_branch();
        load_addr(32'h10);
        send(OP_BEQ, 5'd1, 5'd0, 5'd0, 16'd0, 32'h08, 1'b1, 32'h1020_FFFD, 2'd0);
        send(OP_BEQ, 5'd1, 5'd0, 5'd0, 16'd0, 32'h0002_0018, 1'b1, 32'h0, 2'd2);
        send(OP_BEQ, 5'd2, 5'd3, 5'd0, 16'd0, 32'h0002_0018, 1'b1, 32'h1043_7FFF, 2'd0);
        send(OP_BEQ, 5'd2, 5'd3, 5'd0, 16'd0, 32'h0000_0022, 1'b1, 32'h0, 2'd2);
        drain();
        checks++;
        if (err_any !== 1'b1) begin
            errors++;
            $display("FAIL err_any_set: got %b, expected 1", err_any);
        end
        load_addr(32'h0);
        checks++;
        if (err_any !== 1'b0) begin
            errors++;
            $display("FAIL err_any_clear: got %b after address load, expected 0", err_any);
        end
    endtask

    task automatic test_jump();
        send(OP_J, 5'd0, 5'd0, 5'd0, 16'd0, 32'h40, 1'b1, 32'h0800_0010, 2'd0);
        send(OP_J, 5'd0, 5'd0, 5'd0, 16'd0, 32'h42, 1'b1, 32'h0, 2'd3);
        load_addr(32'h0FFF_FFFC);
        send(OP_J, 5'd0, 5'd0, 5'd0, 16'd0, 32'h40, 1'b1, 32'h0, 2'd3);
        send(4'd12, 5'd1, 5'd2, 5'd3, 16'h1234, 32'd0, 1'b1, 32'h0, 2'd1);
        load_addr(32'hFFFF_FFFF);
        send(OP_J, 5'd0, 5'd0, 5'd0, 16'd0, 32'h40, 1'b1, 32'h0800_0010, 2'd0);
        send(OP_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 32'd0, 1'b0, 32'd0, 2'd0);
        drain();
    endtask

    task automatic test_stall();
        logic [31:0] held;
        out_ready = 1'b0;
        send(OP_ADD, 5'd10, 5'd11, 5'd12, 16'd0, 32'd0, 1'b0, 32'd0, 2'd0);
        send(OP_SUB, 5'd13, 5'd14, 5'd15, 16'd0, 32'd0, 1'b0, 32'd0, 2'd0);
        in_valid = 1'b1; in_op = OP_OR;
        @(negedge clk);
        held = out_instr;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== held) begin
                errors++;
                $display("FAIL stall_hold: rdy=%b v=%b instr=%h, expected 0/1/%h",
                         in_ready, out_valid, out_instr, held);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(OP_OR,  5'd16, 5'd17, 5'd18, 16'd0, 32'd0, 1'b0, 32'd0, 2'd0);
        send(OP_SLT, 5'd19, 5'd20, 5'd21, 16'd0, 32'd0, 1'b0, 32'd0, 2'd0);
        drain();
    endtask

    task automatic test_back_to_back();
        time t0;
        logic [3:0]  op;
        logic [31:0] tgt;
        t0 = $time;
        for (int i = 0; i < 10; i++)
            send(OP_ADDI, 5'(i), 5'(i + 1), 5'd0, 16'(i * 3), 32'd0, 1'b0, 32'd0, 2'd0);
        checks++;
        if ($time - t0 != 100) begin
            errors++;
            $display("FAIL throughput: 10 accepts took %0t, expected 100", $time - t0);
        end
        drain();
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1)
                tgt = m_addr + 32'd4 + 32'(($urandom_range(0, 64) - 32) * 4);
            else if ($urandom_range(0, 1) == 1)
                tgt = {m_addr[31:28] + 4'(m_addr == 32'hFFFF_FFFC), 28'($urandom) & 28'hFFF_FFFC};
            else
                tgt = $urandom;
            send(op, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), tgt,
                 1'b0, 32'd0, 2'd0);
            if ($urandom_range(0, 4) == 0) begin
                idle();
                @(posedge clk); #1;
            end
        end
        idle();
        rand_ready = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(OP_ADD, 5'd1, 5'd1, 5'd1, 16'd0, 32'd0, 1'b0, 32'd0, 2'd0);
        send(OP_SUB, 5'd2, 5'd2, 5'd2, 16'd0, 32'd0, 1'b0, 32'd0, 2'd0);
        idle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: out_valid=%b during reset, expected 0", out_valid);
        end
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        m_addr = RESET_ADDR & ~32'h3;
        repeat (3) @(posedge clk);
        #1;
        send(OP_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 32'd0, 1'b1, 32'h0022_1820, 2'd0);
        drain();
    endtask

    initial begin
        test_reset();
        test_alu_mem();
        test_branch();
        test_jump();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
